npu_host_driver: RTL and testbench
==================================

// Module: npu_host_driver
// PURPOSE
//  Bus-master sequencer for one NPU convolution pass, driving the NPU slave port (ena/wea/addra/dina/douta).
//  Per job: clears NPU state, loads K_W weight words, and runs num_win windows.
//  Each window: load K_W image words, trigger, poll valid, read result, write it to a result buffer.
//  Sits between the job-control register file and the NPU; replaces software polling of the NPU.
// PARAMETERS
//  K_W       3    words per weight set and per image window (one word = K_H packed bytes)
//  WIN_W     8    width of window count/index (max 255 windows)
//  POLL_MAX  15   valid-poll reads before timeout error
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   1-cycle job start; ignored while busy
//  num_win    in   WIN_W  windows in job, sampled on accepted start
//  src_base   in   16  source word address, sampled on accepted start
//  busy       out  1   job in progress
//  done       out  1   1-cycle pulse at job end (also on error)
//  err        out  1   poll timeout; sticky until next accepted start
//  src_re     out  1   source memory read enable
//  src_addr   out  16  source read address
//  src_rdata  in   32  source data, valid exactly 1 cycle after src_re
//  res_we     out  1   result write strobe
//  res_idx    out  WIN_W  window index of result
//  res_data   out  32  result word
//  npu_ena    out  1   NPU access enable
//  npu_wea    out  1   NPU write (1) / read (0)
//  npu_addra  out  16  NPU address; [14:12]=sel, other bits 0
//  npu_dina   out  32  NPU write data
//  npu_douta  in   32  NPU read data, valid the cycle after a read access
// BEHAVIOUR
//  Reset: state IDLE. busy, done, err, src_re, res_we, npu_ena, npu_wea = 0. All buses = 0.
//   Reset mid-job aborts at once; no further NPU accesses are made.
//  Outputs: decoded from registered state/counters/data_q only; no input-to-output combinational path.
//  sel codes: 1 IMG, 2 WGT, 4 CTRL, 6 RESULT, 7 VALID.
//   CTRL bits: 0 trigger, 1 next_state, 2 pe_clr, 3 img_clr, 4 w_clr, 5 pack_clr.
//  Source layout:
//   weights at src_base+0..K_W-1.
//   window w word j at src_base + K_W + w*K_W + j (16-bit wrap).
//  FSM:
//   IDLE    start -> latch params, clear err, busy=1 -> CLR
//   CLR     write CTRL 0x3C -> W_FET
//   W_FET   src_re -> W_CAP; W_CAP data_q<=src_rdata -> W_WR
//   W_WR    write WGT data_q; after K_W words -> (num_win==0 ? NEXT : I_FET)
//   I_FET / I_CAP / I_WR   same pattern with sel IMG; after K_W words -> TRIG
//   TRIG    write CTRL 0x01 -> P_RD
//   P_RD    read VALID, poll_cnt++ -> P_CHK
//   P_CHK   douta[0]=1 -> R_RD
//           else poll_cnt==POLL_MAX -> err=1 -> DONE; else -> P_RD
//   R_RD    read RESULT -> R_CAP
//   R_CAP   res_we=1, res_data=npu_douta, res_idx=win
//           last window -> NEXT; else win++, poll_cnt=0 -> I_FET
//   NEXT    write CTRL 0x02 -> DONE
//   DONE    done=1, busy=0 -> IDLE
//  Timing: each source word costs 3 cycles (fetch, capture, write).
//   Best-case window = 3*K_W + 5 cycles.
//  Bus use: npu_ena=1 only in write/read states, exactly 1 cycle per access.
//   npu_dina=0 on reads.
//  Error path: skips NEXT; result buffer holds only the windows completed so far.
//  start while busy: ignored, latched params unchanged. start in DONE cycle: ignored.
//  poll_cnt: resets per window; counter width ceil(log2(POLL_MAX+1)).
// STRUCTURE
//  npu_host_pkg: sel codes, CTRL bit positions/masks, state_e enum.
//  Sub-module npu_word_mover: fetch/capture/write of N words from src to one NPU sel.
//   Reused for the weight and image loads.
// TESTING
//  1 Reset mid-I_WR -> all outputs 0 next cycle; busy=0; no npu_ena until next start.
//  2 num_win=2, src_base=0x0100, model valid after 1 poll, result=0x11,0x22:
//    writes CTRL 0x3C, WGT x3, IMG x3, CTRL 0x01 per window.
//    Results res_idx 0/1 = 0x11/0x22, then CTRL 0x02, then one done pulse.
//  3 Valid asserted on 4th poll -> exactly 4 reads to 0x7000, then a read to 0x6000, err=0.
//  4 Valid never set -> 15 polls, err=1, done pulse, no CTRL 0x02 write.
//    Next start clears err.
//  5 num_win=0 -> CLR, 3 WGT writes, CTRL 0x02, done; res_we never asserted.
//  6 start pulsed while busy with num_win=9 -> ignored; job finishes with original count.
//    src_base=0xFFFE -> source addresses wrap to 0x0000.

Source files
------------

// File: rtl/npu_host_pkg.sv
// Shared definitions for the NPU host driver: NPU register select codes,
// CTRL register bit layout and the state encodings of both sequencers.
package npu_host_pkg;

    localparam logic [2:0] SEL_IMG    = 3'd1;
    localparam logic [2:0] SEL_WGT    = 3'd2;
    localparam logic [2:0] SEL_CTRL   = 3'd4;
    localparam logic [2:0] SEL_RESULT = 3'd6;
    localparam logic [2:0] SEL_VALID  = 3'd7;

    localparam int CTRL_TRIGGER    = 0;
    localparam int CTRL_NEXT_STATE = 1;
    localparam int CTRL_PE_CLR     = 2;
    localparam int CTRL_IMG_CLR    = 3;
    localparam int CTRL_W_CLR      = 4;
    localparam int CTRL_PACK_CLR   = 5;

    localparam logic [31:0] CTRL_TRIG_MASK = 32'(1) << CTRL_TRIGGER;
    localparam logic [31:0] CTRL_NEXT_MASK = 32'(1) << CTRL_NEXT_STATE;
    localparam logic [31:0] CTRL_CLR_MASK  = (32'(1) << CTRL_PE_CLR)  |
                                             (32'(1) << CTRL_IMG_CLR) |
                                             (32'(1) << CTRL_W_CLR)   |
                                             (32'(1) << CTRL_PACK_CLR);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_W_LOAD,
        ST_I_LOAD,
        ST_TRIG,
        ST_P_RD,
        ST_P_CHK,
        ST_R_RD,
        ST_R_CAP,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MV_IDLE,
        MV_FET,
        MV_CAP,
        MV_WR
    } mv_state_e;

    // NPU address: select code in [14:12], every other bit zero.
    function automatic logic [15:0] npu_addr(input logic [2:0] sel);
        return {1'b0, sel, 12'h000};
    endfunction

endpackage

// File: rtl/npu_word_mover.sv
// Copies N consecutive source words into one NPU select, three cycles per word:
// fetch, capture, write. A go on the final write cycle chains the next burst seamlessly.
import npu_host_pkg::*;

module npu_word_mover #(
    parameter int N = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [15:0] base,
    input  logic [2:0]  sel,
    output logic        src_re,
    output logic [15:0] src_addr,
    input  logic [31:0] src_rdata,
    output logic [15:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        last,
    output mv_state_e   state
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0] cnt;
    logic [15:0]      addr;
    logic [2:0]       sel_q;
    logic [31:0]      data_q;
    logic             final_word;

    assign final_word = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MV_IDLE;
            cnt    <= '0;
            addr   <= '0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                MV_IDLE: begin
                    if (go) begin
                        addr  <= base;
                        sel_q <= sel;
                        cnt   <= '0;
                        state <= MV_FET;
                    end
                end
                MV_FET: state <= MV_CAP;
                MV_CAP: begin
                    data_q <= src_rdata;
                    state  <= MV_WR;
                end
                MV_WR: begin
                    if (final_word) begin
                        if (go) begin
                            addr  <= base;
                            sel_q <= sel;
                            cnt   <= '0;
                            state <= MV_FET;
                        end else begin
                            state <= MV_IDLE;
                        end
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        addr  <= addr + 16'd1;
                        state <= MV_FET;
                    end
                end
                default: state <= MV_IDLE;
            endcase
        end
    end

    // Address wraps naturally in 16 bits; buses stay at zero outside their cycle.
    assign src_re   = (state == MV_FET);
    assign src_addr = src_re ? addr : 16'h0000;
    assign wr_addr  = npu_addr(sel_q);
    assign wr_data  = data_q;
    assign last     = (state == MV_WR) && final_word;

endmodule

// File: rtl/npu_host_driver.sv
// Bus-master sequencer for one NPU convolution pass: clear, load weights,
// then per window load image words, trigger, poll valid and collect the result.
import npu_host_pkg::*;

module npu_host_driver #(
    parameter int K_W      = 3,
    parameter int WIN_W    = 8,
    parameter int POLL_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] num_win,
    input  logic [15:0]      src_base,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             src_re,
    output logic [15:0]      src_addr,
    input  logic [31:0]      src_rdata,
    output logic             res_we,
    output logic [WIN_W-1:0] res_idx,
    output logic [31:0]      res_data,
    output logic             npu_ena,
    output logic             npu_wea,
    output logic [15:0]      npu_addra,
    output logic [31:0]      npu_dina,
    input  logic [31:0]      npu_douta
);

    localparam int PC_W = $clog2(POLL_MAX + 1);

    state_e           state;
    logic [WIN_W-1:0] num_win_q;
    logic [WIN_W-1:0] win;
    logic [15:0]      src_base_q;
    logic [15:0]      img_addr;
    logic [PC_W-1:0]  poll_cnt;
    logic             last_win;

    logic             go_wgt;
    logic             go_img;
    logic             mv_go;
    logic [15:0]      mv_base;
    logic [2:0]       mv_sel;
    logic [15:0]      mv_wr_addr;
    logic [31:0]      mv_wr_data;
    logic             mv_last;
    mv_state_e        mv_state;

    assign last_win = (win == num_win_q - WIN_W'(1));

    // The next burst is requested one cycle early so the mover fetches
    // on the very first cycle of the load state.
    always_comb begin
        go_wgt  = (state == ST_CLR);
        go_img  = ((state == ST_W_LOAD) && mv_last && (num_win_q != '0)) ||
                  ((state == ST_R_CAP) && !last_win);
        mv_go   = go_wgt || go_img;
        mv_base = go_wgt ? src_base_q : img_addr;
        mv_sel  = go_wgt ? SEL_WGT : SEL_IMG;
    end

    npu_word_mover #(
        .N (K_W)
    ) u_mover (
        .clk       (clk),
        .rst       (rst),
        .go        (mv_go),
        .base      (mv_base),
        .sel       (mv_sel),
        .src_re    (src_re),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .wr_addr   (mv_wr_addr),
        .wr_data   (mv_wr_data),
        .last      (mv_last),
        .state     (mv_state)
    );

    // start is a single-cycle request honoured only in IDLE; done pulses for
    // exactly one cycle when the job ends, normally or on poll timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            res_we     <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
            num_win_q  <= '0;
            win        <= '0;
            src_base_q <= '0;
            img_addr   <= '0;
            poll_cnt   <= '0;
        end else begin
            done   <= 1'b0;
            res_we <= 1'b0;
            if (go_img) begin
                img_addr <= img_addr + 16'(K_W);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_win_q  <= num_win;
                        src_base_q <= src_base;
                        img_addr   <= src_base + 16'(K_W);
                        win        <= '0;
                        poll_cnt   <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_CLR;
                    end
                end
                ST_CLR: state <= ST_W_LOAD;
                ST_W_LOAD: begin
                    if (mv_last) begin
                        state <= (num_win_q == '0) ? ST_NEXT : ST_I_LOAD;
                    end
                end
                ST_I_LOAD: begin
                    if (mv_last) begin
                        state <= ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    poll_cnt <= '0;
                    state    <= ST_P_RD;
                end
                ST_P_RD: begin
                    poll_cnt <= poll_cnt + PC_W'(1);
                    state    <= ST_P_CHK;
                end
                ST_P_CHK: begin
                    if (npu_douta[0]) begin
                        state <= ST_R_RD;
                    end else if (poll_cnt == PC_W'(POLL_MAX)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_P_RD;
                    end
                end
                ST_R_RD: state <= ST_R_CAP;
                ST_R_CAP: begin
                    res_we   <= 1'b1;
                    res_data <= npu_douta;
                    res_idx  <= win;
                    if (last_win) begin
                        state <= ST_NEXT;
                    end else begin
                        win      <= win + WIN_W'(1);
                        poll_cnt <= '0;
                        state    <= ST_I_LOAD;
                    end
                end
                ST_NEXT: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        npu_ena   = 1'b0;
        npu_wea   = 1'b0;
        npu_addra = 16'h0000;
        npu_dina  = 32'h0;
        if (mv_state == MV_WR) begin
            npu_ena   = 1'b1;
            npu_wea   = 1'b1;
            npu_addra = mv_wr_addr;
            npu_dina  = mv_wr_data;
        end
        case (state)
            ST_CLR: begin
                npu_ena   = 1'b1;
                npu_wea   = 1'b1;
                npu_addra = npu_addr(SEL_CTRL);
                npu_dina  = CTRL_CLR_MASK;
            end
            ST_TRIG: begin
                npu_ena   = 1'b1;
                npu_wea   = 1'b1;
                npu_addra = npu_addr(SEL_CTRL);
                npu_dina  = CTRL_TRIG_MASK;
            end
            ST_NEXT: begin
                npu_ena   = 1'b1;
                npu_wea   = 1'b1;
                npu_addra = npu_addr(SEL_CTRL);
                npu_dina  = CTRL_NEXT_MASK;
            end
            ST_P_RD: begin
                npu_ena   = 1'b1;
                npu_addra = npu_addr(SEL_VALID);
            end
            ST_R_RD: begin
                npu_ena   = 1'b1;
                npu_addra = npu_addr(SEL_RESULT);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_npu_host_driver.sv
// Directed bench for npu_host_driver with a source-memory model, a small NPU
// model and a scoreboard of expected NPU accesses and result writes.
module tb_npu_host_driver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num_win;
    logic [15:0] src_base;
    logic        busy;
    logic        done;
    logic        err;
    logic        src_re;
    logic [15:0] src_addr;
    logic [31:0] src_rdata = 32'h0;
    logic        res_we;
    logic [7:0]  res_idx;
    logic [31:0] res_data;
    logic        npu_ena;
    logic        npu_wea;
    logic [15:0] npu_addra;
    logic [31:0] npu_dina;
    logic [31:0] npu_douta = 32'h0;

    npu_host_driver #(
        .K_W      (3),
        .WIN_W    (8),
        .POLL_MAX (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_win   (num_win),
        .src_base  (src_base),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .src_re    (src_re),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .res_we    (res_we),
        .res_idx   (res_idx),
        .res_data  (res_data),
        .npu_ena   (npu_ena),
        .npu_wea   (npu_wea),
        .npu_addra (npu_addra),
        .npu_dina  (npu_dina),
        .npu_douta (npu_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory: each word carries its own address so data proves the address.
    always @(posedge clk) begin
        if (src_re) src_rdata <= {src_addr, ~src_addr};
    end

    // NPU model: valid appears on the valid_after-th poll (0 = never),
    // result of window n (1-based) is 0x11*n.
    int valid_after = 1;
    int polls_seen  = 0;
    int trig_n      = 0;
    always @(posedge clk) begin
        if (npu_ena && npu_wea && npu_addra == 16'h4000) begin
            if (npu_dina == 32'h3C) trig_n <= 0;
            if (npu_dina[0]) begin
                trig_n     <= trig_n + 1;
                polls_seen <= 0;
            end
        end
        if (npu_ena && !npu_wea) begin
            if (npu_addra == 16'h7000) begin
                polls_seen <= polls_seen + 1;
                npu_douta  <= (valid_after != 0 && polls_seen + 1 >= valid_after) ? 32'h1 : 32'h0;
            end else if (npu_addra == 16'h6000) begin
                npu_douta <= 32'(32'h11 * trig_n);
            end
        end
    end

    logic [48:0] acc_q[$];
    logic [48:0] exp_q[$];
    logic [39:0] res_q[$];
    int done_cnt = 0;
    int busy_cyc = 0;
    int ena_cnt  = 0;
    always @(negedge clk) begin
        if (npu_ena) begin
            acc_q.push_back({npu_wea, npu_addra, npu_dina});
            ena_cnt <= ena_cnt + 1;
        end
        if (res_we) res_q.push_back({res_idx, res_data});
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a, ~a};
    endfunction

    task automatic build_exp(input logic [15:0] base, input int nwin, input int polls, input bit timeout);
        logic [15:0] a;
        exp_q.delete();
        exp_q.push_back({1'b1, 16'h4000, 32'h3C});
        for (int j = 0; j < 3; j++) begin
            a = base + 16'(j);
            exp_q.push_back({1'b1, 16'h2000, pat(a)});
        end
        for (int w = 0; w < nwin; w++) begin
            for (int j = 0; j < 3; j++) begin
                a = base + 16'(3 + w * 3 + j);
                exp_q.push_back({1'b1, 16'h1000, pat(a)});
            end
            exp_q.push_back({1'b1, 16'h4000, 32'h1});
            for (int p = 0; p < polls; p++) exp_q.push_back({1'b0, 16'h7000, 32'h0});
            if (!timeout) exp_q.push_back({1'b0, 16'h6000, 32'h0});
        end
        if (!timeout) exp_q.push_back({1'b1, 16'h4000, 32'h2});
    endtask

    task automatic start_job(input logic [7:0] nw, input logic [15:0] base);
        @(negedge clk);
        num_win  = nw;
        src_base = base;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_acc(input string tag, input int from);
        check({tag, "_acc_count"}, 64'(acc_q.size() - from), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && from + i < acc_q.size(); i++) begin
            check($sformatf("%s_acc[%0d]", tag, i), 64'(acc_q[from + i]), 64'(exp_q[i]));
        end
    endtask

    int a0, r0, d0, b0, e0, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        num_win  = 8'd0;
        src_base = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({busy, done, err, src_re, res_we, npu_ena, npu_wea}), 64'd0);
        check("rst_addr", 64'({src_addr, npu_addra, res_idx}), 64'd0);
        check("rst_data", 64'({res_data, npu_dina}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of an image write aborts the job immediately.
        start_job(8'd1, 16'h0000);
        n = 0;
        while (!(npu_ena && npu_wea && npu_addra == 16'h1000) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t1_in_img_write", 64'(npu_ena && npu_wea && npu_addra == 16'h1000), 64'd1);
        rst = 1'b1;
        #1;
        check("t1_rst_ctrl", 64'({busy, done, err, src_re, res_we, npu_ena, npu_wea}), 64'd0);
        check("t1_rst_addr", 64'({src_addr, npu_addra, res_idx}), 64'd0);
        check("t1_rst_data", 64'({res_data, npu_dina}), 64'd0);
        @(negedge clk);
        check("t1_busy_next", 64'({busy, npu_ena}), 64'd0);
        rst = 1'b0;
        e0 = ena_cnt;
        repeat (10) @(negedge clk);
        check("t1_no_ena", 64'(ena_cnt - e0), 64'd0);

        // Two windows, valid on first poll.
        valid_after = 1;
        a0 = acc_q.size(); r0 = res_q.size(); d0 = done_cnt; b0 = busy_cyc;
        build_exp(16'h0100, 2, 1, 1'b0);
        start_job(8'd2, 16'h0100);
        wait_done("t2", 300);
        compare_acc("t2", a0);
        check("t2_res_count", 64'(res_q.size() - r0), 64'd2);
        check("t2_res0", 64'((res_q.size() > r0) ? res_q[r0] : 40'hFF_FFFF_FFFF), 64'({8'd0, 32'h11}));
        check("t2_res1", 64'((res_q.size() > r0 + 1) ? res_q[r0 + 1] : 40'hFF_FFFF_FFFF), 64'({8'd1, 32'h22}));
        check("t2_err", 64'(err), 64'd0);
        check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t2_busy_cycles", 64'(busy_cyc - b0), 64'd39);

        // Valid on the fourth poll.
        valid_after = 4;
        a0 = acc_q.size(); r0 = res_q.size(); d0 = done_cnt; b0 = busy_cyc;
        build_exp(16'h0200, 1, 4, 1'b0);
        start_job(8'd1, 16'h0200);
        wait_done("t3", 300);
        compare_acc("t3", a0);
        check("t3_res0", 64'((res_q.size() > r0) ? res_q[r0] : 40'hFF_FFFF_FFFF), 64'({8'd0, 32'h11}));
        check("t3_err", 64'(err), 64'd0);
        check("t3_busy_cycles", 64'(busy_cyc - b0), 64'd31);

        // Valid never arrives: 15 polls then error, no NEXT write.
        valid_after = 0;
        a0 = acc_q.size(); r0 = res_q.size(); d0 = done_cnt; b0 = busy_cyc;
        build_exp(16'h0300, 1, 15, 1'b1);
        start_job(8'd1, 16'h0300);
        wait_done("t4", 400);
        compare_acc("t4", a0);
        check("t4_err", 64'(err), 64'd1);
        check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t4_res_count", 64'(res_q.size() - r0), 64'd0);
        check("t4_busy_cycles", 64'(busy_cyc - b0), 64'd50);

        // Zero windows; the accepted start also clears the sticky error.
        valid_after = 1;
        a0 = acc_q.size(); r0 = res_q.size(); d0 = done_cnt;
        build_exp(16'h0040, 0, 1, 1'b0);
        start_job(8'd0, 16'h0040);
        check("t5_err_cleared", 64'({err, busy}), 64'b01);
        wait_done("t5", 200);
        compare_acc("t5", a0);
        check("t5_res_count", 64'(res_q.size() - r0), 64'd0);
        check("t5_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Start while busy is ignored; source addresses wrap past 0xFFFF.
        a0 = acc_q.size(); r0 = res_q.size(); d0 = done_cnt;
        build_exp(16'hFFFE, 1, 1, 1'b0);
        start_job(8'd1, 16'hFFFE);
        repeat (3) @(negedge clk);
        num_win  = 8'd9;
        src_base = 16'h1234;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done("t6", 300);
        compare_acc("t6", a0);
        check("t6_res_count", 64'(res_q.size() - r0), 64'd1);
        check("t6_res0", 64'((res_q.size() > r0) ? res_q[r0] : 40'hFF_FFFF_FFFF), 64'({8'd0, 32'h11}));
        check("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t6_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
